// File: rtl/usb_xcvr_defines_pkg.sv
// Shared definitions for the USB transceiver receive path: FSM state
// encodings and the default word width.
package usb_xcvr_defines;

  localparam int USB_BYTE_W = 8;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/rx_sipo.sv
// Serial-in parallel-out shift register with bit counter. word_out is the
// word including the bit being accepted this cycle, so the hold register
// can capture a completed word at the same edge as its last bit.
module rx_sipo #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  bit_in,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic                  word_done
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sr_q;
  logic [DATA_WIDTH-1:0] sr_d;
  logic [CNT_W-1:0]      cnt_q;

  always_comb begin
    sr_d = sr_q;
    if (MSB_FIRST) begin
      sr_d = {sr_q[DATA_WIDTH-2:0], bit_in};
    end else begin
      sr_d = {bit_in, sr_q[DATA_WIDTH-1:1]};
    end
  end

  assign word_out  = sr_d;
  assign word_done = shift_en && (cnt_q == LAST_CNT);

  // A clear discards the partial count but leaves the shift contents alone;
  // the next full word overwrites every bit anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (shift_en) begin
      sr_q  <= sr_d;
      cnt_q <= word_done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/rx_shift_hold.sv
// Receive shift/hold path: assembles serial bits into words, hands them to
// the receive controller via a hold register, and flags overrun/truncation.
module rx_shift_hold
  import usb_xcvr_defines::*;
#(
  parameter int DATA_WIDTH = USB_BYTE_W,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  Rx_Shift_Hold_Clk,
  input  logic                  Rx_Shift_Hold_Rst,
  input  logic                  Rx_Shift_Hold_Data_In,
  input  logic                  Rx_Shift_Hold_Bit_Valid,
  input  logic                  Rx_Shift_Hold_Active,
  input  logic                  Rx_Shift_Hold_Read,
  output logic [DATA_WIDTH-1:0] Rx_Shift_Hold_Data_Out,
  output logic                  Rx_Shift_Hold_Data_Valid,
  output logic                  Rx_Shift_Hold_Byte_Strobe,
  output logic                  Rx_Shift_Hold_Overrun,
  output logic                  Rx_Shift_Hold_Partial
);

  rx_state_e             state_q;
  logic                  pending_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  valid_q;
  logic                  strobe_q;
  logic                  overrun_q;
  logic                  partial_q;

  logic                  shift_en;
  logic                  clr;
  logic                  read_hit;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_done;

  // Bits are accepted in IDLE too, so the cycle Active rises carries bit 0.
  assign shift_en = Rx_Shift_Hold_Active && Rx_Shift_Hold_Bit_Valid;
  assign clr      = !Rx_Shift_Hold_Active;
  assign read_hit = Rx_Shift_Hold_Read && valid_q;

  rx_sipo #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_sipo (
    .clk       (Rx_Shift_Hold_Clk),
    .rst       (Rx_Shift_Hold_Rst),
    .shift_en  (shift_en),
    .bit_in    (Rx_Shift_Hold_Data_In),
    .clr       (clr),
    .word_out  (word),
    .word_done (word_done)
  );

  // pending_q mirrors "sipo count is non-zero" so a falling Active can
  // decide whether a truncated word is being thrown away.
  always_ff @(posedge Rx_Shift_Hold_Clk) begin
    if (Rx_Shift_Hold_Rst) begin
      state_q   <= RX_IDLE;
      pending_q <= 1'b0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      strobe_q  <= 1'b0;
      partial_q <= 1'b0;

      case (state_q)
        RX_IDLE: begin
          if (Rx_Shift_Hold_Active) state_q <= RX_SHIFT;
        end
        RX_SHIFT: begin
          if (!Rx_Shift_Hold_Active) begin
            state_q   <= RX_IDLE;
            partial_q <= pending_q;
          end
        end
        default: state_q <= RX_IDLE;
      endcase

      if (shift_en) begin
        pending_q <= !word_done;
      end else if (clr) begin
        pending_q <= 1'b0;
      end

      // A read landing on a completing edge consumes the old word, so the
      // new one replaces it cleanly without flagging overrun.
      if (word_done) begin
        hold_q   <= word;
        valid_q  <= 1'b1;
        strobe_q <= 1'b1;
        if (valid_q && !Rx_Shift_Hold_Read) begin
          overrun_q <= 1'b1;
        end else if (read_hit) begin
          overrun_q <= 1'b0;
        end
      end else if (read_hit) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign Rx_Shift_Hold_Data_Out    = hold_q;
  assign Rx_Shift_Hold_Data_Valid  = valid_q;
  assign Rx_Shift_Hold_Byte_Strobe = strobe_q;
  assign Rx_Shift_Hold_Overrun     = overrun_q;
  assign Rx_Shift_Hold_Partial     = partial_q;

endmodule

// File: tb/tb_rx_shift_hold.sv
// Directed bench for rx_shift_hold: an MSB-first and an LSB-first instance
// share one stimulus stream and are checked against hand-computed values.
module tb_rx_shift_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic       dataIn;
  logic       bitValid;
  logic       active;
  logic       rdAck;

  logic [7:0] msbData;
  logic       msbValid, msbStrobe, msbOverrun, msbPartial;
  logic [7:0] lsbData;
  logic       lsbValid, lsbStrobe, lsbOverrun, lsbPartial;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  rx_shift_hold #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .Rx_Shift_Hold_Clk         (clk),
    .Rx_Shift_Hold_Rst         (rst),
    .Rx_Shift_Hold_Data_In     (dataIn),
    .Rx_Shift_Hold_Bit_Valid   (bitValid),
    .Rx_Shift_Hold_Active      (active),
    .Rx_Shift_Hold_Read        (rdAck),
    .Rx_Shift_Hold_Data_Out    (msbData),
    .Rx_Shift_Hold_Data_Valid  (msbValid),
    .Rx_Shift_Hold_Byte_Strobe (msbStrobe),
    .Rx_Shift_Hold_Overrun     (msbOverrun),
    .Rx_Shift_Hold_Partial     (msbPartial)
  );

  rx_shift_hold #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
    .Rx_Shift_Hold_Clk         (clk),
    .Rx_Shift_Hold_Rst         (rst),
    .Rx_Shift_Hold_Data_In     (dataIn),
    .Rx_Shift_Hold_Bit_Valid   (bitValid),
    .Rx_Shift_Hold_Active      (active),
    .Rx_Shift_Hold_Read        (rdAck),
    .Rx_Shift_Hold_Data_Out    (lsbData),
    .Rx_Shift_Hold_Data_Valid  (lsbValid),
    .Rx_Shift_Hold_Byte_Strobe (lsbStrobe),
    .Rx_Shift_Hold_Overrun     (lsbOverrun),
    .Rx_Shift_Hold_Partial     (lsbPartial)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; outputs are then sampled 1ns after the edge.
  task automatic applyStimulus(input logic act, input logic vld,
                               input logic bitVal, input logic rd);
    active   = act;
    bitValid = vld;
    dataIn   = bitVal;
    rdAck    = rd;
    @(posedge clk);
    #1;
  endtask

  // Sends a byte MSB-first on the wire, optionally reading on the last bit.
  task automatic sendByte(input logic [7:0] b, input logic readOnLast);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b1, b[i], (i == 0) ? readOnLast : 1'b0);
    end
  endtask

  initial begin
    logic [7:0] pat;

    rst = 1'b1;
    active = 1'b0; bitValid = 1'b0; dataIn = 1'b0; rdAck = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_data",    32'(msbData), 32'h00);
    checkOutput("rst_valid",   32'(msbValid), 32'h0);
    checkOutput("rst_strobe",  32'(msbStrobe), 32'h0);
    checkOutput("rst_overrun", 32'(msbOverrun), 32'h0);
    checkOutput("rst_partial", 32'(msbPartial), 32'h0);
    rst = 1'b0;

    // Reset mid-word: 4 bits in, reset arrives with bit 4
    pat = 8'hFF;
    for (int i = 7; i >= 4; i--) applyStimulus(1'b1, 1'b1, pat[i], 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("midrst_valid",  32'(msbValid), 32'h0);
    checkOutput("midrst_strobe", 32'(msbStrobe), 32'h0);
    checkOutput("midrst_data",   32'(msbData), 32'h00);
    rst = 1'b0;

    // Single byte A5 (palindromic, so both bit orders give A5)
    pat = 8'hA5;
    for (int i = 7; i >= 1; i--) applyStimulus(1'b1, 1'b1, pat[i], 1'b0);
    checkOutput("a5_no_early_strobe", 32'(msbStrobe), 32'h0);
    applyStimulus(1'b1, 1'b1, pat[0], 1'b0);
    checkOutput("a5_data",     32'(msbData), 32'hA5);
    checkOutput("a5_valid",    32'(msbValid), 32'h1);
    checkOutput("a5_strobe",   32'(msbStrobe), 32'h1);
    checkOutput("a5_lsb_data", 32'(lsbData), 32'hA5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("a5_strobe_one_cycle", 32'(msbStrobe), 32'h0);
    checkOutput("a5_valid_held",       32'(msbValid), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("a5_read_clears", 32'(msbValid), 32'h0);
    checkOutput("a5_data_kept",   32'(msbData), 32'hA5);

    // Gapped bits: 1 then seven 0s, Bit_Valid every third cycle
    pat = 8'h80;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b1, pat[i], 1'b0);
      if (i != 0) begin
        checkOutput("gap_no_strobe", 32'(lsbStrobe), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      end
    end
    checkOutput("gap_lsb_data",   32'(lsbData), 32'h01);
    checkOutput("gap_lsb_strobe", 32'(lsbStrobe), 32'h1);
    checkOutput("gap_msb_data",   32'(msbData), 32'h80);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Overrun: 3C unread, then C3
    sendByte(8'h3C, 1'b0);
    checkOutput("ovr_first_data",    32'(msbData), 32'h3C);
    checkOutput("ovr_first_overrun", 32'(msbOverrun), 32'h0);
    sendByte(8'hC3, 1'b0);
    checkOutput("ovr_data",    32'(msbData), 32'hC3);
    checkOutput("ovr_overrun", 32'(msbOverrun), 32'h1);
    checkOutput("ovr_valid",   32'(msbValid), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_sticky", 32'(msbOverrun), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_read_valid",   32'(msbValid), 32'h0);
    checkOutput("ovr_read_overrun", 32'(msbOverrun), 32'h0);

    // Read coinciding with completion: no overrun
    sendByte(8'h3C, 1'b0);
    sendByte(8'hC3, 1'b1);
    checkOutput("rdcomp_data",    32'(msbData), 32'hC3);
    checkOutput("rdcomp_valid",   32'(msbValid), 32'h1);
    checkOutput("rdcomp_overrun", 32'(msbOverrun), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    // Truncation after 5 bits with 3C held
    sendByte(8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("trunc_no_early_partial", 32'(msbPartial), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("trunc_partial", 32'(msbPartial), 32'h1);
    checkOutput("trunc_data",    32'(msbData), 32'h3C);
    checkOutput("trunc_valid",   32'(msbValid), 32'h1);
    checkOutput("trunc_strobe",  32'(msbStrobe), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("trunc_partial_pulse", 32'(msbPartial), 32'h0);
    checkOutput("trunc_read", 32'(msbValid), 32'h0);
    sendByte(8'h5A, 1'b0);
    checkOutput("trunc_clean_data", 32'(msbData), 32'h5A);
    checkOutput("trunc_clean_lsb",  32'(lsbData), 32'h5A);
    checkOutput("trunc_clean_ovr",  32'(msbOverrun), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("drop_cnt0_no_partial", 32'(msbPartial), 32'h0);

    // Active falls together with what would be the 8th bit
    pat = 8'hFF;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, pat[i], 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("lastbit_drop_partial", 32'(msbPartial), 32'h1);
    checkOutput("lastbit_drop_strobe",  32'(msbStrobe), 32'h0);
    checkOutput("lastbit_drop_valid",   32'(msbValid), 32'h0);

    // Bit_Valid pulses with Active low are ignored
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("ign_strobe",  32'(msbStrobe), 32'h0);
      checkOutput("ign_partial", 32'(msbPartial), 32'h0);
    end
    pat = 8'hF0;
    for (int i = 7; i >= 1; i--) applyStimulus(1'b1, 1'b1, pat[i], 1'b0);
    checkOutput("ign_no_early_strobe", 32'(msbStrobe), 32'h0);
    applyStimulus(1'b1, 1'b1, pat[0], 1'b0);
    checkOutput("ign_word_data",  32'(msbData), 32'hF0);
    checkOutput("ign_word_lsb",   32'(lsbData), 32'h0F);
    checkOutput("ign_word_strobe", 32'(msbStrobe), 32'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rx_shift_hold.md
Name: rx_shift_hold

Overview:
Receive-side counterpart of the transmit shift/hold path in the USB transceiver. Accepts a qualified serial bit stream (post-NRZI decode / bit-unstuff), assembles MSB-first bytes in a serial-in shift register, and transfers each completed byte into a hold register for the receive controller. Flags overrun when a byte completes before the previous one is consumed, and flags a truncated byte at end of packet.

Parameters:
DATA_WIDTH, 8, bits per assembled word; must be >= 2.
MSB_FIRST, 1, 1: first received bit lands in Data_Out[DATA_WIDTH-1]; 0: in Data_Out[0].

Ports:
Rx_Shift_Hold_Clk  input  1  clock; all logic on posedge.
Rx_Shift_Hold_Rst  input  1  synchronous, active-high reset.
Rx_Shift_Hold_Data_In  input  1  serial data bit.
Rx_Shift_Hold_Bit_Valid  input  1  qualifies Data_In for one cycle.
Rx_Shift_Hold_Active  input  1  packet-in-progress level from the SYNC/EOP detector.
Rx_Shift_Hold_Read  input  1  consumer acknowledge for the hold register.
Rx_Shift_Hold_Data_Out  output  DATA_WIDTH  hold register contents.
Rx_Shift_Hold_Data_Valid  output  1  level: hold register holds an unread word.
Rx_Shift_Hold_Byte_Strobe  output  1  one-cycle pulse: a new word was loaded.
Rx_Shift_Hold_Overrun  output  1  sticky: an unread word was overwritten.
Rx_Shift_Hold_Partial  output  1  one-cycle pulse: Active dropped mid-word.

Behaviour:
- Reset: priority over all inputs; state IDLE, bit count 0, shift reg 0; all outputs 0.
- States: IDLE (no packet) and SHIFT (packet active).
- IDLE -> SHIFT when Active=1. A bit with Bit_Valid=1 in that same cycle is accepted as bit 0.
- SHIFT -> IDLE when Active=0.
- Bit acceptance requires Active=1 and Bit_Valid=1. Bit_Valid while Active=0 is ignored.
- Shift rule, MSB_FIRST=1: sr <= {sr[W-2:0], Data_In}. MSB_FIRST=0: sr <= {Data_In, sr[W-1:1]}.
- Bit count runs 0..W-1 and is clog2(W) bits wide.
- Completion: accepting a bit while count=W-1 triggers, at that same edge:
  - Data_Out <= assembled word, including this bit
  - Data_Valid <= 1
  - Byte_Strobe <= 1 for exactly one cycle
  - count <= 0
- Latency: Data_Out is visible the cycle after the last bit is sampled. Back-to-back words need no gap cycles.
- Read with Data_Valid=1: clears Data_Valid and Overrun at the edge. Read with Data_Valid=0 has no effect.
- Completion and Read in the same cycle: new word loaded, Data_Valid stays 1, no overrun.
- Completion with Data_Valid=1 and Read=0: newest word overwrites Data_Out, Overrun <= 1. Overrun holds until Read or Rst.
- Active falls with count != 0:
  - partial bits discarded; count <= 0; sr unchanged
  - Partial pulses one cycle
  - hold register and Data_Valid untouched
- Active falls with count=0: no Partial pulse.
- Active falls in the same cycle as a final bit: that bit is not accepted (Active=0). The pending partial word raises Partial.
- Hold register changes only on completion or reset; never while partial bits are being shifted.

Decomposition:
- Shared package/include usb_xcvr_defines holds:
  - state encodings RX_IDLE=1'b0, RX_SHIFT=1'b1
  - default data width constant USB_BYTE_W=8
- Sub-module rx_sipo holds the shift register and bit counter, with ports clk, rst, shift_en, bit_in, clr, word_out, word_done.
- rx_shift_hold contains the FSM, hold register, and flag logic around rx_sipo.

Test Plan:
- Reset mid-word: Rst during bit 4 -> all outputs 0, count 0. Next 8 bits 10100101 give Data_Out=8'hA5 with no residue from the earlier word.
- Single byte: Active=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> one cycle after the 8th bit, Data_Out=8'hA5, Data_Valid=1, one-cycle Byte_Strobe. Read -> Data_Valid=0 next cycle.
- Gapped bits and LSB-first: MSB_FIRST=0, Bit_Valid every 3rd cycle, bits 1,0,0,0,0,0,0,0 -> Data_Out=8'h01. No Byte_Strobe before the 8th valid bit.
- Overrun: send 8'h3C, no Read, then 8'hC3 -> Data_Out=8'hC3, Overrun=1. Read clears Data_Valid and Overrun. Repeat with Read coinciding with the completing edge -> Overrun stays 0.
- Truncation: Active drops after 5 bits -> Partial pulses once, prior hold contents and Data_Valid unchanged. Next packet's first 8 bits form a clean word. Active drop at count=0 -> no Partial.
- Ignored bits: Bit_Valid pulses with Active=0 -> no count change, no strobes.
